// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants, vertical phase type and the line-to-phase decode
// shared by the vertical counter and the sync generator.
package vga_timing_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_FP         = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BP         = 10'd48;
    localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;

    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_FP         = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BP         = 10'd33;
    localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;
    localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;

    typedef enum logic [1:0] {
        VIS,
        VFP,
        VSYNC,
        VBP
    } v_phase_t;

    function automatic v_phase_t phase_of(input logic [9:0] line);
        if (line < V_VISIBLE)
            return VIS;
        else if (line < V_SYNC_START)
            return VFP;
        else if (line <= V_SYNC_END)
            return VSYNC;
        else
            return VBP;
    endfunction

endpackage

// File: rtl/v_counter.sv
// Vertical line register: advances once per v_en pulse and wraps after the last line
// of the frame. The combinational next value lets the top see a new line in the v_en cycle.
module v_counter
    import vga_timing_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       v_en,
    output logic [9:0] v_count,
    output logic [9:0] v_count_next
);

    logic [9:0] v_count_reg;

    assign v_count_next = (v_count_reg == V_LAST) ? 10'd0 : v_count_reg + 10'd1;
    assign v_count      = v_count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n)
            v_count_reg <= 10'd0;
        else if (v_en)
            v_count_reg <= v_count_next;
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Vertical timing and registered sync/enable/pixel-coordinate generation for 640x480@60.
// Every output lags h_count by one clock and uses the effective line so boundaries align with h_count == 0.
module vga_sync_gen
    import vga_timing_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] h_count,
    input  logic       v_en,
    output logic [9:0] v_count,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [8:0] pixel_y,
    output logic       frame_start
);

    logic [9:0] v_count_next;
    logic [9:0] v_line;
    v_phase_t   phase_reg;
    v_phase_t   line_phase;

    logic       h_legal;
    logic       hsync_n_next, vsync_n_next, video_on_next, frame_start_next;
    logic [9:0] pixel_x_next;
    logic [8:0] pixel_y_next;
    logic       hsync_n_reg, vsync_n_reg, video_on_reg, frame_start_reg;
    logic [9:0] pixel_x_reg;
    logic [8:0] pixel_y_reg;

    v_counter u_v_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .v_en         (v_en),
        .v_count      (v_count),
        .v_count_next (v_count_next)
    );

    assign v_line     = v_en ? v_count_next : v_count;
    // Phase is re-decoded from the new line on every v_en, so a stale phase cannot outlive one line.
    assign line_phase = v_en ? phase_of(v_count_next) : phase_reg;
    assign h_legal    = (h_count < H_TOTAL);

    always_comb begin
        hsync_n_next     = ~(h_legal && (h_count >= H_SYNC_START) && (h_count <= H_SYNC_END));
        vsync_n_next     = (line_phase != VSYNC);
        video_on_next    = (h_count < H_VISIBLE) && (line_phase == VIS);
        pixel_x_next     = video_on_next ? h_count : 10'd0;
        pixel_y_next     = video_on_next ? v_line[8:0] : 9'd0;
        frame_start_next = (h_count == 10'd0) && (v_line == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_reg       <= VIS;
            hsync_n_reg     <= 1'b1;
            vsync_n_reg     <= 1'b1;
            video_on_reg    <= 1'b0;
            pixel_x_reg     <= 10'd0;
            pixel_y_reg     <= 9'd0;
            frame_start_reg <= 1'b0;
        end else begin
            if (v_en)
                phase_reg <= line_phase;
            hsync_n_reg     <= hsync_n_next;
            vsync_n_reg     <= vsync_n_next;
            video_on_reg    <= video_on_next;
            pixel_x_reg     <= pixel_x_next;
            pixel_y_reg     <= pixel_y_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign hsync_n     = hsync_n_reg;
    assign vsync_n     = vsync_n_reg;
    assign video_on    = video_on_reg;
    assign pixel_x     = pixel_x_reg;
    assign pixel_y     = pixel_y_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: directed phases with randomized h_count, checked
// every clock against an arithmetic model of the 640x480@60 timing rules.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] h_count;
    logic       v_en;
    logic [9:0] v_count;
    logic       hsync_n;
    logic       vsync_n;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [8:0] pixel_y;
    logic       frame_start;

    always #20 clk = ~clk;

    vga_sync_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_count     (h_count),
        .v_en        (v_en),
        .v_count     (v_count),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;
    int m_vc      = 0;   // model line count
    int hs_low_cnt    = 0;
    int vs_low_cnt    = 0;
    int vid_cnt       = 0;
    int vid_blank_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d (line %0d)", tag, obs, exp, m_vc);
    endtask

    // One clock: drive inputs, predict outputs from the timing rules, check after the edge.
    task automatic step(input bit rst, input int h, input bit en);
        int line;
        int e_hs, e_vs, e_vid, e_px, e_py, e_fs;
        rst_n   = rst;
        h_count = h[9:0];
        v_en    = en;
        if (!rst) begin
            line = 0; e_hs = 1; e_vs = 1; e_vid = 0; e_px = 0; e_py = 0; e_fs = 0;
        end else begin
            line  = en ? ((m_vc + 1) % 525) : m_vc;
            e_vs  = (line == 490 || line == 491) ? 0 : 1;
            e_vid = (h < 640 && line < 480) ? 1 : 0;
            e_hs  = (h >= 656 && h <= 751) ? 0 : 1;
            e_px  = e_vid ? h : 0;
            e_py  = e_vid ? line : 0;
            e_fs  = (h == 0 && line == 0) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        m_vc = line;
        chk("v_count",     32'(v_count),     line);
        chk("hsync_n",     32'(hsync_n),     e_hs);
        chk("vsync_n",     32'(vsync_n),     e_vs);
        chk("video_on",    32'(video_on),    e_vid);
        chk("pixel_x",     32'(pixel_x),     e_px);
        chk("pixel_y",     32'(pixel_y),     e_py);
        chk("frame_start", 32'(frame_start), e_fs);
        if (hsync_n === 1'b0) hs_low_cnt++;
        if (vsync_n === 1'b0) vs_low_cnt++;
        if (video_on === 1'b1) vid_cnt++;
        if (video_on === 1'b1 && m_vc >= 480) vid_blank_cnt++;
    endtask

    task automatic line_short(input int n);
        step(1, 0, 1);
        for (int k = 1; k < n; k++) step(1, int'($urandom_range(1, 1023)), 0);
    endtask

    task automatic line_full();
        step(1, 0, 1);
        for (int h = 1; h < 800; h++) step(1, h, 0);
    endtask

    // Advance with short lines until the next v_en enters the target line.
    task automatic goto_line(input int target);
        while (m_vc != (target + 524) % 525) line_short(4);
    endtask

    initial begin
        rst_n = 1'b0; h_count = 10'd0; v_en = 1'b0;

        for (int i = 0; i < 5; i++) step(0, int'($urandom_range(0, 799)), 1'($urandom_range(0, 1)));
        $display("reset: 5 clocks with random v_en, v_count=%0d", v_count);

        goto_line(10);
        hs_low_cnt = 0; vid_cnt = 0;
        line_full();
        chk("hsync_low_clocks_line10", hs_low_cnt, 96);
        chk("video_on_clocks_line10", vid_cnt, 640);
        $display("line 10: hsync low %0d clocks, video_on %0d clocks", hs_low_cnt, vid_cnt);

        goto_line(200);
        step(1, 0, 1);
        step(1, 0, 1);
        $display("back-to-back v_en: v_count=%0d", v_count);

        goto_line(490);
        vs_low_cnt = 0;
        line_full();
        line_full();
        line_short(4);
        chk("vsync_low_clocks", vs_low_cnt, 1600);
        $display("vsync: low for %0d clocks over lines 490..491", vs_low_cnt);

        goto_line(0);
        chk("video_on_in_vblank", vid_blank_cnt, 0);
        step(1, 0, 1);
        step(1, 1, 0);
        $display("wrap: v_count=%0d pixel=(%0d,%0d)", v_count, pixel_x, pixel_y);

        goto_line(100);
        step(1, 900, 0);
        for (int i = 0; i < 6; i++) step(1, int'($urandom_range(800, 1023)), 0);
        $display("illegal h_count on line 100: v_count=%0d video_on=%0b", v_count, video_on);

        goto_line(300);
        step(1, 40, 0);
        step(0, 50, 1);
        step(1, 51, 0);
        line_short(6);
        $display("mid-frame reset at line 300: resumed at v_count=%0d", v_count);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
